// File: rtl/sram_pkg.sv
// Shared types and sizes for the sequencer-side SRAM responder.
package sram_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 1024;

    // INIT clears the array after reset; RUN serves the bus.
    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } state_e;

    // Decoded view of the two active-low strobes.
    typedef enum logic [1:0] {
        CmdIdle  = 2'd0,
        CmdRead  = 2'd1,
        CmdWrite = 2'd2,
        CmdBoth  = 2'd3
    } cmd_e;

    function automatic cmd_e decode_cmd(input logic rd_n, input logic wr_n);
        cmd_e cmd;
        case ({rd_n, wr_n})
            2'b01:   cmd = CmdRead;
            2'b10:   cmd = CmdWrite;
            2'b00:   cmd = CmdBoth;
            default: cmd = CmdIdle;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/sram_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module sram_array
    import sram_pkg::*;
#(
    parameter int unsigned Depth = DEPTH,
    parameter int unsigned DataW = DATA_W,
    parameter int unsigned AddrW = ADDR_W
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AddrW-1:0] i_waddr,
    input  logic [DataW-1:0] i_wdata,
    input  logic [AddrW-1:0] i_raddr,
    output logic [DataW-1:0] o_rdata
);

    logic [DataW-1:0] r_mem [Depth];

    // Commit a write on the rising edge; contents are not reset (cleared by the owner).
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sram_resp.sv
// Memory-side responder for the sequencer SRAM bus: post-reset clear, zero-latency
// reads, edge-committed writes, sticky protocol-error flags and saturating counters.
module sram_resp
    import sram_pkg::*;
#(
    parameter logic [DATA_W-1:0] INIT_VAL = 32'h0000_0000,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_,
    input  logic              wr_,
    inout  wire  [DATA_W-1:0] mem,
    output logic              busy,
    output logic              err_both,
    output logic              err_early,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e             r_state;
    state_e             w_state_d;
    logic [ADDR_W-1:0]  r_init_addr;
    logic [ADDR_W-1:0]  w_init_addr_d;
    logic               r_err_both;
    logic               w_err_both_d;
    logic               r_err_early;
    logic               w_err_early_d;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic [CNT_W-1:0]   w_rd_cnt_d;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic [CNT_W-1:0]   w_wr_cnt_d;

    cmd_e               w_cmd;
    logic               w_in_run;
    logic               w_rd_ok;
    logic               w_wr_ok;
    logic               w_any_strobe;
    logic               w_we;
    logic [ADDR_W-1:0]  w_waddr;
    logic [DATA_W-1:0]  w_wdata;
    logic [DATA_W-1:0]  w_rdata;

    // Decode the bus; only RUN-state single-strobe cycles are legal accesses.
    always_comb begin
        w_cmd        = decode_cmd(rd_, wr_);
        w_in_run     = (r_state == StRun);
        w_rd_ok      = w_in_run && (w_cmd == CmdRead);
        w_wr_ok      = w_in_run && (w_cmd == CmdWrite);
        w_any_strobe = !rd_ || !wr_;
    end

    // Write-port mux: the clear sweep owns the port in INIT, the bus in RUN.
    always_comb begin
        w_we    = !w_in_run || w_wr_ok;
        w_waddr = w_in_run ? addr : r_init_addr;
        w_wdata = w_in_run ? mem : INIT_VAL;
    end

    sram_array #(
        .Depth (DEPTH),
        .DataW (DATA_W),
        .AddrW (ADDR_W)
    ) u_array (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (addr),
        .o_rdata (w_rdata)
    );

    // Drive the bus only during a legal read; no turnaround cycle.
    assign mem = w_rd_ok ? w_rdata : {DATA_W{1'bz}};

    // FSM next state: sweep init_addr up to the last word, then hand over to RUN.
    always_comb begin
        w_state_d     = r_state;
        w_init_addr_d = r_init_addr;
        case (r_state)
            StInit: begin
                if (r_init_addr == LastAddr) begin
                    w_state_d = StRun;
                end else begin
                    w_init_addr_d = r_init_addr + 1'b1;
                end
            end
            StRun: begin
                w_state_d = StRun;
            end
            default: begin
                w_state_d     = StInit;
                w_init_addr_d = '0;
            end
        endcase
    end

    // Sticky error flags and saturating access counters.
    always_comb begin
        w_err_early_d = r_err_early || (!w_in_run && w_any_strobe);
        w_err_both_d  = r_err_both || (w_in_run && (w_cmd == CmdBoth));
        w_rd_cnt_d    = r_rd_cnt;
        w_wr_cnt_d    = r_wr_cnt;
        if (w_rd_ok && (r_rd_cnt != {CNT_W{1'b1}})) begin
            w_rd_cnt_d = r_rd_cnt + 1'b1;
        end
        if (w_wr_ok && (r_wr_cnt != {CNT_W{1'b1}})) begin
            w_wr_cnt_d = r_wr_cnt + 1'b1;
        end
    end

    // State register; reset restarts the clear from address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StInit;
            r_init_addr <= '0;
            r_err_both  <= 1'b0;
            r_err_early <= 1'b0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
        end else begin
            r_state     <= w_state_d;
            r_init_addr <= w_init_addr_d;
            r_err_both  <= w_err_both_d;
            r_err_early <= w_err_early_d;
            r_rd_cnt    <= w_rd_cnt_d;
            r_wr_cnt    <= w_wr_cnt_d;
        end
    end

    assign busy      = (r_state == StInit);
    assign err_both  = r_err_both;
    assign err_early = r_err_early;
    assign rd_cnt    = r_rd_cnt;
    assign wr_cnt    = r_wr_cnt;

endmodule

// File: tb/tb_sram_resp.sv
// Directed self-checking bench for sram_resp. The bus has a pull-up, so an
// undriven bus reads all-ones and stands in for high-Z.
module tb_sram_resp;

    localparam logic [31:0] Pull = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic [9:0]  addr;
    logic        rd_n;
    logic        wr_n;
    logic        drv_en;
    logic [31:0] drv_data;
    tri1  [31:0] mem_bus;
    logic        busy;
    logic        err_both;
    logic        err_early;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    // Second instance with narrow counters for the saturation test.
    logic [9:0]  addr4;
    logic        wr4_n;
    logic        drv4_en;
    logic [31:0] drv4_data;
    tri1  [31:0] mem_bus4;
    logic        busy4;
    logic        err_both4;
    logic        err_early4;
    logic [3:0]  rd_cnt4;
    logic [3:0]  wr_cnt4;

    int n_checks;
    int n_fail;

    assign mem_bus  = drv_en ? drv_data : 32'hz;
    assign mem_bus4 = drv4_en ? drv4_data : 32'hz;

    sram_resp u_dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .rd_       (rd_n),
        .wr_       (wr_n),
        .mem       (mem_bus),
        .busy      (busy),
        .err_both  (err_both),
        .err_early (err_early),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt)
    );

    sram_resp #(
        .CNT_W (4)
    ) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr4),
        .rd_       (1'b1),
        .wr_       (wr4_n),
        .mem       (mem_bus4),
        .busy      (busy4),
        .err_both  (err_both4),
        .err_early (err_early4),
        .rd_cnt    (rd_cnt4),
        .wr_cnt    (wr_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        drv_en = 1'b0;
    endtask

    task automatic reset_and_clear();
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
        repeat (1024) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        addr     = a;
        wr_n     = 1'b0;
        rd_n     = 1'b1;
        drv_en   = 1'b1;
        drv_data = d;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic bus_read(input logic [9:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a;
        rd_n = 1'b0;
        wr_n = 1'b1;
        #2;
        d = mem_bus;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        int          bad;
        logic [31:0] d;
        @(negedge clk);
        rst = 1'b1;
        idle();
        #2;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_busy: got %b want 1", busy);
        end
        n_checks++;
        if ({err_both, err_early} !== 2'b00) begin
            n_fail++; $display("FAIL reset_err: got %b want 00", {err_both, err_early});
        end
        n_checks++;
        if ({rd_cnt, wr_cnt} !== 32'h0) begin
            n_fail++; $display("FAIL reset_cnt: got rd=%0d wr=%0d want 0 0", rd_cnt, wr_cnt);
        end
        n_checks++;
        if (mem_bus !== Pull) begin
            n_fail++; $display("FAIL reset_bus_z: got %h want %h", mem_bus, Pull);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 1; i <= 1024; i++) begin
            @(posedge clk);
            #1;
            if (i < 1024 && busy !== 1'b1) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL clear_busy_high: got %0d low cycles want 0", bad);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL clear_busy_fall: got %b want 0 after edge 1024", busy);
        end
        n_checks++;
        if ({rd_cnt, wr_cnt} !== 32'h0) begin
            n_fail++; $display("FAIL clear_cnt: got rd=%0d wr=%0d want 0 0", rd_cnt, wr_cnt);
        end
        bus_read(10'd0, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL clear_read_0: got %h want 00000000", d);
        end
        bus_read(10'd511, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL clear_read_511: got %h want 00000000", d);
        end
        bus_read(10'd1023, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL clear_read_1023: got %h want 00000000", d);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] d;
        reset_and_clear();
        bus_write(10'h155, 32'hDEAD_BEEF);
        bus_read(10'h155, d);
        n_checks++;
        if (d !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL wr_rd_data: got %h want deadbeef", d);
        end
        n_checks++;
        if (wr_cnt !== 16'd1 || rd_cnt !== 16'd1) begin
            n_fail++; $display("FAIL wr_rd_cnt: got rd=%0d wr=%0d want 1 1", rd_cnt, wr_cnt);
        end
    endtask

    task automatic test_both_low();
        logic [31:0] d;
        @(negedge clk);
        addr     = 10'd5;
        rd_n     = 1'b0;
        wr_n     = 1'b0;
        drv_en   = 1'b1;
        drv_data = 32'h1234_5678;
        #2;
        n_checks++;
        if (mem_bus !== 32'h1234_5678) begin
            n_fail++; $display("FAIL both_bus: got %h want 12345678", mem_bus);
        end
        @(posedge clk);
        #1;
        idle();
        n_checks++;
        if (err_both !== 1'b1 || err_early !== 1'b0) begin
            n_fail++; $display("FAIL both_flag: got both=%b early=%b want 1 0", err_both, err_early);
        end
        n_checks++;
        if (wr_cnt !== 16'd1 || rd_cnt !== 16'd1) begin
            n_fail++; $display("FAIL both_cnt: got rd=%0d wr=%0d want 1 1", rd_cnt, wr_cnt);
        end
        // Both-low on a non-zero word with the bench released: the bus must stay pulled.
        @(negedge clk);
        addr = 10'h155;
        rd_n = 1'b0;
        wr_n = 1'b0;
        #2;
        n_checks++;
        if (mem_bus !== Pull) begin
            n_fail++; $display("FAIL both_no_drive: got %h want %h", mem_bus, Pull);
        end
        @(posedge clk);
        #1;
        idle();
        bus_read(10'd5, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL both_no_write: got %h want 00000000", d);
        end
        n_checks++;
        if (err_both !== 1'b1) begin
            n_fail++; $display("FAIL both_sticky: got %b want 1", err_both);
        end
    endtask

    task automatic test_early();
        int bad;
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 1; i <= 1024; i++) begin
            @(posedge clk);
            #1;
            if (i < 1024 && busy !== 1'b1) bad++;
            if (i == 99) begin
                addr = 10'd3;
                rd_n = 1'b0;
                #2;
                n_checks++;
                if (mem_bus !== Pull) begin
                    n_fail++; $display("FAIL early_bus_z: got %h want %h", mem_bus, Pull);
                end
            end
            if (i == 100) begin
                idle();
                n_checks++;
                if (err_early !== 1'b1) begin
                    n_fail++; $display("FAIL early_flag: got %b want 1", err_early);
                end
            end
        end
        n_checks++;
        if (bad !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL early_clear: got %0d low cycles busy=%b want 0 0", bad, busy);
        end
        n_checks++;
        if (rd_cnt !== 16'd0 || err_both !== 1'b0) begin
            n_fail++; $display("FAIL early_cnt: got rd=%0d both=%b want 0 0", rd_cnt, err_both);
        end
    endtask

    task automatic test_fill_readback();
        int          bad;
        logic [31:0] d;
        for (int i = 0; i < 1024; i++) bus_write(10'(i), 32'(i));
        n_checks++;
        if (wr_cnt !== 16'd1024) begin
            n_fail++; $display("FAIL fill_wr_cnt: got %0d want 1024", wr_cnt);
        end
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            bus_read(10'(i), d);
            if (d !== 32'(i)) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL fill_readback: got %0d bad words want 0", bad);
        end
        n_checks++;
        if (rd_cnt !== 16'd512) begin
            n_fail++; $display("FAIL fill_rd_cnt: got %0d want 512", rd_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        idle();
        #2;
        n_checks++;
        if (busy !== 1'b1 || rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
            n_fail++; $display("FAIL mid_reset: got busy=%b rd=%0d wr=%0d want 1 0 0",
                                busy, rd_cnt, wr_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (1024) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_clear: got busy=%b want 0", busy);
        end
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            bus_read(10'(i), d);
            if (d !== 32'h0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL mid_reset_zero: got %0d nonzero words want 0", bad);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            addr4     = 10'(i);
            wr4_n     = 1'b0;
            drv4_en   = 1'b1;
            drv4_data = 32'(i);
            @(posedge clk);
            #1;
            wr4_n   = 1'b1;
            drv4_en = 1'b0;
            if (i == 13) begin
                n_checks++;
                if (wr_cnt4 !== 4'hE) begin
                    n_fail++; $display("FAIL sat_14: got %h want e", wr_cnt4);
                end
            end
            if (i == 15) begin
                n_checks++;
                if (wr_cnt4 !== 4'hF) begin
                    n_fail++; $display("FAIL sat_16: got %h want f", wr_cnt4);
                end
            end
        end
        n_checks++;
        if (wr_cnt4 !== 4'hF || rd_cnt4 !== 4'h0) begin
            n_fail++; $display("FAIL sat_stick: got wr=%h rd=%h want f 0", wr_cnt4, rd_cnt4);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        addr      = '0;
        drv_data  = '0;
        idle();
        addr4     = '0;
        wr4_n     = 1'b1;
        drv4_en   = 1'b0;
        drv4_data = '0;
        test_reset();
        test_write_read();
        test_both_low();
        test_early();
        test_fill_readback();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_resp.md
# sram_resp

Synthesizable memory-side responder for the 32-bit single-port SRAM bus driven by the sequencer: `addr[9:0]`, active-low `rd_`/`wr_` strobes and bidirectional `mem[31:0]`. It stores 1024 x 32 words and serves reads combinationally within the strobe cycle. It commits writes on the clock edge and clears the whole array after every reset. It also keeps sticky protocol-error flags and saturating access counters for bring-up debug, and replaces the behavioural SRAM model in the synthesizable top level.

## Interface
- `INIT_VAL`, 32'h0000_0000, word written to every location during the post-reset clear.
- `CNT_W`, 16, width of the read/write access counters.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `addr`  in  10  word address from the sequencer.
- `rd_`  in  1  active-low read strobe.
- `wr_`  in  1  active-low write strobe.
- `mem`  inout  32  shared data bus. Driven by `sram_resp` only during a legal read; otherwise high-Z.
- `busy`  out  1  high while the post-reset clear runs.
- `err_both`  out  1  sticky: `rd_` and `wr_` were low in the same cycle.
- `err_early`  out  1  sticky: a strobe was low while `busy` was high.
- `rd_cnt`  out  CNT_W  count of accepted reads, saturating.
- `wr_cnt`  out  CNT_W  count of accepted writes, saturating.

## Operation
- The block has two states, INIT and RUN.
- Reset (asynchronous assert) forces the following, from any state:
  - state = INIT, `init_addr` = 0;
  - `busy` = 1;
  - `err_both` = `err_early` = 0;
  - `rd_cnt` = `wr_cnt` = 0;
  - `mem` = Z.
- INIT behaviour:
  - Each rising edge writes `INIT_VAL` to array[`init_addr`], then `init_addr` increments.
  - The edge that writes address 1023 moves the state to RUN and clears `busy`.
  - Strobes seen during INIT are ignored: no array access from the bus, no bus drive, counters unchanged. Any low strobe sets `err_early` at that edge.
- RUN behaviour:
  - Legal read (`rd_`=0, `wr_`=1): `mem` = array[`addr`] combinationally. `rd_cnt` increments at the edge.
  - Legal write (`wr_`=0, `rd_`=1): array[`addr`] <= `mem` at the edge. `wr_cnt` increments.
  - Both strobes low: no drive, no write, counters unchanged, `err_both` set at the edge.
  - Both strobes high: idle.
- Counters saturate at all-ones and never wrap.
- Error flags are cleared only by `rst`.

## Timing
- Read latency is zero cycles. `mem` is valid a combinational delay after `rd_` falls or `addr` changes, so the sequencer can sample it at the next rising edge in the same cycle.
- A write is visible to a read one cycle later. A read in cycle N+1 to the address written in cycle N returns the new data. There is no same-cycle read/write, because that case is the both-strobes-low error.
- Bus drive enable is purely combinational: (state==RUN) & !`rd_` & `wr_`. There is no turnaround cycle; the sequencer guarantees it drives `mem` only while `wr_` is low.
- The clear occupies exactly 1024 edges after `rst` deasserts. `busy` falls after edge 1024, and the first legal access is in cycle 1025.
- Reset asserted mid-INIT or mid-RUN aborts immediately and restarts the clear at address 0. Array contents written before the reset are not guaranteed after it.
- Address 1023 during INIT is the terminal count. `init_addr` does not wrap back into a second pass.

## Structure
- Shared package `sram_pkg`: `ADDR_W`=10, `DATA_W`=32, `DEPTH`=1024, and the state encoding (INIT, RUN).
- Sub-module `sram_array`: DEPTH x DATA_W storage with one synchronous write port and one asynchronous read port.
- The write-port mux (INIT vs bus), the FSM, the counters, the error flags and the tristate stay in `sram_resp`.

## Test plan
- Reset, then hold strobes high for 1024 cycles -> `busy`=1 throughout and falls after edge 1024. A read of addresses 0, 511 and 1023 returns 32'h0; both counters are 0.
- Write 32'hDEAD_BEEF to address 10'h155, then read it the next cycle -> `mem`=32'hDEAD_BEEF during the read, `wr_cnt`=1, `rd_cnt`=1.
- Drive `rd_`=`wr_`=0 at address 5 with bus value 32'h1234_5678 -> `err_both`=1. Address 5 still reads 0, `mem` is not driven by `sram_resp` that cycle, and the counters are unchanged.
- Pulse `rd_` low at cycle 100 after reset -> `err_early`=1, `mem`=Z, and the clear still completes at edge 1024.
- Write addresses 0 to 1023 with data = address, then read them back -> every word matches. Assert `rst` mid-readback -> `busy` returns to 1, and after the next clear all words read 0.
- Force `wr_cnt` near saturation with CNT_W=4 (16 writes) -> the counter sticks at 4'hF and does not wrap.
